// File: rtl/ball_sprite_pipe.sv
// Two-stage pixel colour generator: NUM_BALLS 8x8 circle sprites over walls, paddles, header and background.
// Optional speed-blink of fast balls is enabled by defining PIXGEN_BLINK_EN.
module ball_sprite_pipe #(
  parameter int NUM_BALLS   = 4,
  parameter int COORD_W     = 10,
  parameter int TOP_MARGIN  = 25,
  parameter int PADDLE_H    = 72,
  parameter int BLINK_SPEED = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           pixel_tick,
  input  logic                           frame_start,
  input  logic [COORD_W-1:0]             x,
  input  logic [COORD_W-1:0]             y,
  input  logic                           video_on,
  input  logic [NUM_BALLS*COORD_W-1:0]   ball_x,
  input  logic [NUM_BALLS*COORD_W-1:0]   ball_y,
  input  logic [NUM_BALLS-1:0]           ball_en,
  input  logic [COORD_W-1:0]             paddle1_y,
  input  logic [COORD_W-1:0]             paddle2_y,
  input  logic [11:0]                    bg_pixel,
  input  logic [11:0]                    game_over_pixel,
  input  logic [11:0]                    text_rgb,
  input  logic                           text_on,
  input  logic                           game_over,
  input  logic [3:0]                     ball_speed,
  output logic [11:0]                    rgb,
  output logic                           rgb_valid,
  output logic                           overlap_flag
);

  localparam int W1 = COORD_W + 1;

  typedef enum logic [2:0] {R_OFF, R_GOVER, R_HDR, R_WALL, R_PAD, R_BALL, R_BG} region_e;

  function automatic logic [7:0] sprite_row(input logic [2:0] r);
    case (r)
      3'd0, 3'd7: sprite_row = 8'h3C;
      3'd1, 3'd6: sprite_row = 8'h7E;
      default:    sprite_row = 8'hFF;
    endcase
  endfunction

  logic [NUM_BALLS-1:0] hit;
  logic [3:0]           hits_n;
  logic [COORD_W-1:0]   bx, by;
  logic [2:0]           row, col;
  logic [7:0]           srow;
  logic                 in_box;

  // Every channel has its own ROM lookup so overlapping boxes never mask each other.
  always_comb begin
    hit    = '0;
    hits_n = '0;
    bx     = '0;
    by     = '0;
    row    = '0;
    col    = '0;
    srow   = '0;
    in_box = 1'b0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      bx     = ball_x[i*COORD_W +: COORD_W];
      by     = ball_y[i*COORD_W +: COORD_W];
      in_box = ({1'b0, x} >= {1'b0, bx}) && ({1'b0, x} <= {1'b0, bx} + W1'(7)) &&
               ({1'b0, y} >= {1'b0, by}) && ({1'b0, y} <= {1'b0, by} + W1'(7));
      row    = y[2:0] - by[2:0];
      col    = x[2:0] - bx[2:0];
      srow   = sprite_row(row);
      hit[i] = ball_en[i] & in_box & srow[3'd7 - col];
      hits_n = hits_n + {3'b000, hit[i]};
    end
  end

  logic [5:0] frame_cnt_q, frame_cnt_d;
  logic       blink;

`ifdef PIXGEN_BLINK_EN
  assign blink = frame_cnt_q[3] && (ball_speed >= 4'(BLINK_SPEED));
`else
  // Counter keeps running for debug visibility even though nothing blinks.
  assign blink = 1'b0 && ((^frame_cnt_q) || (ball_speed >= 4'(BLINK_SPEED)));
`endif

  logic [W1-1:0] p1_top, p2_top;
  logic          pad1, pad2;
  region_e       region_d, region_q;
  logic [11:0]   src_d, src_q;
  logic [3:0]    spd_q;

  always_comb begin
    p1_top   = {1'b0, paddle1_y} + W1'(TOP_MARGIN);
    p2_top   = {1'b0, paddle2_y} + W1'(TOP_MARGIN);
    pad1     = (x >= COORD_W'(32)) && (x <= COORD_W'(40)) &&
               ({1'b0, y} >= p1_top) && ({1'b0, y} <= p1_top + W1'(PADDLE_H));
    pad2     = (x >= COORD_W'(600)) && (x <= COORD_W'(608)) &&
               ({1'b0, y} >= p2_top) && ({1'b0, y} <= p2_top + W1'(PADDLE_H));
    region_d = R_BG;
    src_d    = bg_pixel;
    if (!video_on) begin
      region_d = R_OFF;
    end else if (game_over) begin
      region_d = R_GOVER;
      src_d    = game_over_pixel;
    end else if (y < COORD_W'(TOP_MARGIN)) begin
      region_d = R_HDR;
      src_d    = text_on ? text_rgb : 12'h135;
    end else if ((x < COORD_W'(32)) || (x > COORD_W'(608))) begin
      region_d = R_WALL;
    end else if (pad1 || pad2) begin
      region_d = R_PAD;
    end else if ((|hit) && !blink) begin
      region_d = R_BALL;
    end
  end

  logic [11:0] rgb_d, rgb_q;

  always_comb begin
    rgb_d = 12'h000;
    case (region_q)
      R_GOVER, R_HDR, R_BG: rgb_d = src_q;
      R_WALL:               rgb_d = 12'h89C;
      R_PAD:                rgb_d = 12'h24F;
      R_BALL: begin
        case (spd_q)
          4'd3:    rgb_d = 12'hFF0;
          4'd4:    rgb_d = 12'h0F0;
          4'd5:    rgb_d = 12'hF00;
          default: rgb_d = 12'h135;
        endcase
      end
      default:              rgb_d = 12'h000;
    endcase
  end

  logic v1_q, valid_q, acc_q, acc_d, flag_q, flag_d;

  // An overlap seen on the frame_start tick itself is dropped, not carried into the new frame.
  always_comb begin
    acc_d       = acc_q | (hits_n >= 4'd2);
    flag_d      = flag_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start) begin
      flag_d      = acc_q;
      acc_d       = 1'b0;
      frame_cnt_d = frame_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      region_q    <= R_OFF;
      src_q       <= '0;
      spd_q       <= '0;
      rgb_q       <= '0;
      v1_q        <= 1'b0;
      valid_q     <= 1'b0;
      acc_q       <= 1'b0;
      flag_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else if (pixel_tick) begin
      region_q    <= region_d;
      src_q       <= src_d;
      spd_q       <= ball_speed;
      rgb_q       <= rgb_d;
      v1_q        <= 1'b1;
      valid_q     <= v1_q;
      acc_q       <= acc_d;
      flag_q      <= flag_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign rgb          = rgb_q;
  assign rgb_valid    = valid_q;
  assign overlap_flag = flag_q;

endmodule
